sr_alu_wb_stage: RTL and testbench

- Writeback stage directly downstream of the ALU.
- Accepts ALU results with a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains entries to the register-file write port whenever that port is granted.
- Keeps the sticky saturation flag (OV) driven by the packed-SIMD saturating shifts, and provides operand forwarding from buffered entries back to decode/execute.

---
 rtl/sr_alu_wb_stage.sv | 155 +++++++++++++++
 tb/tb_sr_alu_wb_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_alu_wb_stage.sv
// sr_alu_wb_stage
// Writeback stage that sits behind the ALU. Results arrive on a valid/ready
// handshake, are buffered in a small in-order FIFO, and drain to the
// register-file write port whenever it is granted. The stage also holds the
// sticky saturation flag (OV) and forwards buffered values to decode/execute.
module sr_alu_wb_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    // ALU result handshake
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wen,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_ov,
    input  logic            ex_ov_en,
    // register-file write port
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    // operand forwarding
    input  logic [4:0]      fwd_rs1,
    input  logic [4:0]      fwd_rs2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    // OV flag CSR access
    input  logic            csr_we,
    input  logic            csr_wdata,
    output logic            ov_flag
);

    // Pointers are log2(DEPTH) bits and wrap on their own; the occupancy
    // counter needs one extra bit so that "full" is distinguishable from "empty".
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW:0]     count_reg;
    logic [AW:0]     count_next;
    logic            ov_reg;
    logic            ov_next;

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic            accept;
    logic            enq;
    logic            deq;

    // Per-slot occupancy and forwarding match vectors, plus the slot that
    // holds the entry of each age (age 0 = head/oldest).
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic [AW-1:0]    age_slot [DEPTH];

    // Handshake qualifiers. Results that do not write a real register are
    // consumed without occupying a FIFO slot.
    assign ex_ready = (count_reg < DEPTH_CNT);
    assign wb_valid = (count_reg != '0);
    assign accept   = ex_valid & ex_ready;
    assign enq      = accept & ex_wen & (ex_rd != 5'd0);
    assign deq      = wb_valid & wb_ready;

    // Head entry is presented straight from the registered storage.
    assign wb_rd   = rd_mem[rd_ptr_reg];
    assign wb_data = data_mem[rd_ptr_reg];
    assign ov_flag = ov_reg;

    // Occupancy update: enqueue and dequeue in the same cycle cancel out.
    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Sticky OV: a CSR write replaces the held value, but a saturation from an
    // accepted result in the same cycle always wins and sets the flag.
    always_comb begin
        ov_next = (csr_we ? csr_wdata : ov_reg) | (accept & ex_ov_en & ex_ov);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ov_reg     <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            ov_reg    <= ov_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Storage for one slot; cleared on reset so nothing undefined can
            // reach wb_* or the forwarding muxes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_mem[gi]   <= 5'd0;
                    data_mem[gi] <= '0;
                end else if (enq && (wr_ptr_reg == AW'(gi))) begin
                    rd_mem[gi]   <= ex_rd;
                    data_mem[gi] <= ex_result;
                end
            end

            // A slot is live when its distance from the head is below count.
            logic [AW-1:0] slot_age;
            assign slot_age       = AW'(gi) - rd_ptr_reg;
            assign slot_valid[gi] = ({1'b0, slot_age} < count_reg);
            assign match1[gi]     = slot_valid[gi] & (rd_mem[gi] == fwd_rs1) & (fwd_rs1 != 5'd0);
            assign match2[gi]     = slot_valid[gi] & (rd_mem[gi] == fwd_rs2) & (fwd_rs2 != 5'd0);
            assign age_slot[gi]   = rd_ptr_reg + AW'(gi);
        end
    endgenerate

    // Forwarding: scan from oldest to youngest so the youngest match wins.
    // The entry leaving this cycle is still live, the incoming ex_* is not.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match1[age_slot[i]]) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_mem[age_slot[i]];
            end
            if (match2[age_slot[i]]) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_mem[age_slot[i]];
            end
        end
    end

endmodule

// File: tb/tb_sr_alu_wb_stage.sv
// Testbench for sr_alu_wb_stage: directed vectors with literal expectations,
// plus a queue-based reference model compared against the DUT every cycle.
module tb_sr_alu_wb_stage;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd;
    logic            ex_wen;
    logic [XLEN-1:0] ex_result;
    logic            ex_ov;
    logic            ex_ov_en;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      fwd_rs1;
    logic [4:0]      fwd_rs2;
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;
    logic            csr_we;
    logic            csr_wdata;
    logic            ov_flag;

    int n_vec = 0;
    int n_err = 0;

    sr_alu_wb_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_result(ex_result), .ex_ov(ex_ov), .ex_ov_en(ex_ov_en),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .csr_we(csr_we), .csr_wdata(csr_wdata), .ov_flag(ov_flag)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_ov   = 1'b0;
    bit   m_live = 1'b0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            q.delete();
            m_ov   = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            acc  = ex_valid && (q.size() < DEPTH);
            m_ov = (csr_we ? csr_wdata : m_ov) | (acc & ex_ov_en & ex_ov);
            if (q.size() != 0 && wb_ready) void'(q.pop_front());
            if (acc && ex_wen && ex_rd != 5'd0) q.push_back('{rd: ex_rd, data: ex_result});
        end
    end

    function automatic logic [XLEN:0] model_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == rs) return {1'b1, q[i].data};
        return '0;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Compare process: DUT vs model on every falling edge once reset is seen.
    always @(negedge clk) begin
        logic [XLEN:0] f1;
        logic [XLEN:0] f2;
        if (m_live && !rst) begin
            f1 = model_fwd(fwd_rs1);
            f2 = model_fwd(fwd_rs2);
            cmp("m_ex_ready", 64'(ex_ready), 64'(q.size() < DEPTH));
            cmp("m_wb_valid", 64'(wb_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                cmp("m_wb_rd", 64'(wb_rd), 64'(q[0].rd));
                cmp("m_wb_data", 64'(wb_data), 64'(q[0].data));
            end
            cmp("m_fwd1", {31'd0, fwd_hit1, fwd_data1}, 64'(f1));
            cmp("m_fwd2", {31'd0, fwd_hit2, fwd_data2}, 64'(f2));
            cmp("m_ov_flag", 64'(ov_flag), 64'(m_ov));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [4:0] rd, input logic [XLEN-1:0] d);
        ex_valid  = 1'b1;
        ex_wen    = 1'b1;
        ex_rd     = rd;
        ex_result = d;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_rd = 0; ex_wen = 0; ex_result = 0;
        ex_ov = 0; ex_ov_en = 0; wb_ready = 0; fwd_rs1 = 0; fwd_rs2 = 0;
        csr_we = 0; csr_wdata = 0;
        step(); step();
        rst = 1'b0;
        cmp("init_wb_valid", 64'(wb_valid), 64'd0);
        cmp("init_ex_ready", 64'(ex_ready), 64'd1);

        // Fill two entries with the write port blocked, then drain.
        put(5'd3, 32'h1234_5678); step();
        cmp("one_wb_rd", 64'(wb_rd), 64'd3);
        put(5'd4, 32'hDEAD_BEEF); step();
        ex_valid = 0;
        cmp("full_ex_ready", 64'(ex_ready), 64'd0);
        step();
        cmp("hold_wb_rd", 64'(wb_rd), 64'd3);
        cmp("hold_wb_data", 64'(wb_data), 64'h1234_5678);
        wb_ready = 1; step();
        cmp("drain1_wb_rd", 64'(wb_rd), 64'd4);
        cmp("drain1_wb_data", 64'(wb_data), 64'hDEAD_BEEF);
        step();
        cmp("drain2_wb_valid", 64'(wb_valid), 64'd0);
        wb_ready = 0;

        // Reset with a full FIFO and OV set; rst wins over a concurrent accept.
        put(5'd5, 32'hAAAA_0001); ex_ov_en = 1; ex_ov = 1; step();
        ex_ov_en = 0; ex_ov = 0;
        put(5'd6, 32'hAAAA_0002); step();
        fwd_rs1 = 5'd5; #1;
        cmp("pre_rst_hit1", 64'(fwd_hit1), 64'd1);
        cmp("pre_rst_ov", 64'(ov_flag), 64'd1);
        rst = 1; put(5'd9, 32'h5555_5555); ex_ov_en = 1; ex_ov = 1; wb_ready = 1;
        step();
        rst = 0; ex_valid = 0; ex_ov_en = 0; ex_ov = 0; wb_ready = 0;
        cmp("rst_wb_valid", 64'(wb_valid), 64'd0);
        cmp("rst_ex_ready", 64'(ex_ready), 64'd1);
        cmp("rst_ov", 64'(ov_flag), 64'd0);
        cmp("rst_hit1", 64'(fwd_hit1), 64'd0);
        fwd_rs1 = 0;

        // Full FIFO with concurrent dequeue and offered item.
        put(5'd1, 32'hA); step();
        put(5'd2, 32'hB); step();
        put(5'd8, 32'hC); wb_ready = 1; step();
        cmp("full_deq_wb_rd", 64'(wb_rd), 64'd2);
        cmp("full_deq_ex_ready", 64'(ex_ready), 64'd1);
        step();
        cmp("late_acc_wb_rd", 64'(wb_rd), 64'd8);
        cmp("late_acc_wb_data", 64'(wb_data), 64'hC);
        ex_valid = 0; step();
        cmp("late_drain_valid", 64'(wb_valid), 64'd0);

        // Stream 8 back-to-back items through the wrapping pointers.
        for (int i = 0; i < 8; i++) begin
            put(5'(10 + i), 32'h0101_0101 * (i + 1)); step();
            cmp("stream_wb_rd", 64'(wb_rd), 64'(10 + i));
            cmp("stream_wb_data", 64'(wb_data), 64'(32'h0101_0101 * (i + 1)));
        end
        ex_valid = 0; step();
        cmp("stream_end_valid", 64'(wb_valid), 64'd0);
        wb_ready = 0;

        // Forwarding picks the youngest matching entry.
        put(5'd7, 32'h11); step();
        put(5'd7, 32'h22); step();
        ex_valid = 0; fwd_rs1 = 5'd7; fwd_rs2 = 5'd0; #1;
        cmp("fwd_hit1", 64'(fwd_hit1), 64'd1);
        cmp("fwd_data1", 64'(fwd_data1), 64'h22);
        cmp("fwd_hit2", 64'(fwd_hit2), 64'd0);
        cmp("fwd_data2", 64'(fwd_data2), 64'd0);
        wb_ready = 1; #1;
        cmp("fwd_deq_hit1", 64'(fwd_hit1), 64'd1);
        step();
        wb_ready = 0;
        cmp("fwd_one_data1", 64'(fwd_data1), 64'h22);
        put(5'd9, 32'h99); ex_wen = 0; step();
        cmp("nowen_ex_ready", 64'(ex_ready), 64'd1);
        cmp("nowen_wb_rd", 64'(wb_rd), 64'd7);
        put(5'd0, 32'h77); step();
        ex_valid = 0; fwd_rs2 = 5'd9; #1;
        cmp("rd0_ex_ready", 64'(ex_ready), 64'd1);
        cmp("rd0_hit2", 64'(fwd_hit2), 64'd0);
        wb_ready = 1; step();
        cmp("fwd_drain_valid", 64'(wb_valid), 64'd0);
        fwd_rs1 = 0; fwd_rs2 = 0;

        // OV flag behaviour.
        put(5'd12, 32'h7F7F_7F7F); ex_ov_en = 1; ex_ov = 1; step();
        cmp("ov_set", 64'(ov_flag), 64'd1);
        ex_valid = 0; ex_ov_en = 0; ex_ov = 0; csr_we = 1; csr_wdata = 0; step();
        csr_we = 0;
        cmp("ov_csr_clr", 64'(ov_flag), 64'd0);
        put(5'd13, 32'h1); ex_ov = 1; ex_ov_en = 0; step();
        cmp("ov_no_en", 64'(ov_flag), 64'd0);
        ex_valid = 0; ex_ov = 0; step();
        wb_ready = 0;
        put(5'd14, 32'h2); step();
        put(5'd15, 32'h3); step();
        ex_ov_en = 1; ex_ov = 1; put(5'd16, 32'h4); step();
        cmp("ov_not_ready", 64'(ov_flag), 64'd0);
        ex_valid = 0; ex_ov_en = 0; ex_ov = 0; wb_ready = 1; step(); step();
        cmp("ov_drained", 64'(wb_valid), 64'd0);
        put(5'd17, 32'h5); ex_ov_en = 1; ex_ov = 1; csr_we = 1; csr_wdata = 0; step();
        cmp("ov_clr_vs_sat", 64'(ov_flag), 64'd1);
        ex_valid = 0; ex_ov_en = 0; ex_ov = 0; step();
        cmp("ov_clr_again", 64'(ov_flag), 64'd0);
        csr_wdata = 1; step();
        cmp("ov_csr_set", 64'(ov_flag), 64'd1);
        csr_we = 0; csr_wdata = 0; step(); step();
        cmp("ov_sticky", 64'(ov_flag), 64'd1);

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
